wb_stage_exc: RTL and testbench

- Parametrised write-back stage for the LoongArch pipeline; successor to the single-cycle WB register.
- Latches the MEM->WB payload under a valid/allowin handshake and commits register writes.
- Resolves an N-source exception vector to ecode/esubcode/badv, and raises ertn and refetch flushes.
- Adds a post-flush squash window, CSR back-pressure stall, and retire/exception counters.

---
 rtl/wb_pkg.sv | 45 ++++
 rtl/wb_exc_prio.sv | 19 +
 rtl/wb_stage_exc.sv | 167 ++++++++++++++++
 tb/tb_wb_stage_exc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: exception codes, the priority
// table that maps exc_vec bit positions to ecode/esubcode/BADV behaviour, FSM states.
package wb_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic [8:0] ESUBCODE_NONE = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esubcode;
        logic       badv_en;
        logic       badv_from_pc;
    } exc_entry_t;

    // Index = exc_vec bit position; lower index wins.
    localparam exc_entry_t EXC_TABLE [10] = '{
        '{ECODE_INT,  ESUBCODE_NONE, 1'b0, 1'b0},
        '{ECODE_ADE,  ESUBCODE_ADEF, 1'b1, 1'b1},
        '{ECODE_TLBR, ESUBCODE_NONE, 1'b1, 1'b1},
        '{ECODE_PIF,  ESUBCODE_NONE, 1'b1, 1'b1},
        '{ECODE_PPI,  ESUBCODE_NONE, 1'b1, 1'b1},
        '{ECODE_INE,  ESUBCODE_NONE, 1'b0, 1'b0},
        '{ECODE_SYS,  ESUBCODE_NONE, 1'b0, 1'b0},
        '{ECODE_BRK,  ESUBCODE_NONE, 1'b0, 1'b0},
        '{ECODE_ALE,  ESUBCODE_NONE, 1'b1, 1'b0},
        '{ECODE_ADE,  ESUBCODE_ADEM, 1'b1, 1'b0}
    };

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } wb_state_e;

endpackage

// File: rtl/wb_exc_prio.sv
// Lowest-set-bit priority encoder over the exception vector.
module wb_exc_prio #(
    parameter int NUM_EXC = 10
) (
    input  logic [NUM_EXC-1:0] exc_vec,
    output logic               exc_any,
    output logic [3:0]         exc_idx
);

    assign exc_any = |exc_vec;

    always_comb begin
        exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_vec[i]) exc_idx = 4'(i);
        end
    end

endmodule

// File: rtl/wb_stage_exc.sv
// LoongArch write-back stage: commits register writes, resolves exceptions,
// raises ertn/refetch flushes, squashes MEM traffic after a flush, counts retires.
module wb_stage_exc #(
    parameter int NUM_EXC    = 10,
    parameter int FLUSH_HOLD = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ms_to_ws_valid,
    output logic               ws_allowin,
    input  logic [31:0]        ms_pc,
    input  logic               ms_rf_we,
    input  logic [4:0]         ms_rf_waddr,
    input  logic [31:0]        ms_rf_wdata,
    input  logic [NUM_EXC-1:0] ms_exc_vec,
    input  logic               ms_ertn,
    input  logic               ms_refetch,
    input  logic [31:0]        ms_badv,
    input  logic               csr_stall,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic               wb_ex,
    output logic [5:0]         wb_ecode,
    output logic [8:0]         wb_esubcode,
    output logic [31:0]        wb_pc,
    output logic [31:0]        wb_badv,
    output logic               wb_badv_we,
    output logic               ertn_flush,
    output logic               refetch_flush,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   exc_cnt,
    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [31:0]        debug_wb_rf_wdata
);
    import wb_pkg::*;

    localparam int HOLD_W = $clog2(FLUSH_HOLD + 2);

    logic               ws_valid;
    logic [31:0]        ws_pc;
    logic               ws_rf_we;
    logic [4:0]         ws_rf_waddr;
    logic [31:0]        ws_rf_wdata;
    logic [NUM_EXC-1:0] ws_exc_vec;
    logic               ws_ertn;
    logic               ws_refetch;
    logic [31:0]        ws_badv;

    wb_state_e          state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               accept;

    logic               ws_ready_go, commit, flush, capture;
    logic               exc_any;
    logic [3:0]         exc_idx;
    exc_entry_t         sel;

    wb_exc_prio #(.NUM_EXC(NUM_EXC)) u_prio (
        .exc_vec (ws_exc_vec),
        .exc_any (exc_any),
        .exc_idx (exc_idx)
    );

    assign sel         = EXC_TABLE[exc_idx];
    assign ws_ready_go = ~(ws_valid & csr_stall);
    assign ws_allowin  = ~ws_valid | ws_ready_go;
    assign commit      = ws_valid & ws_ready_go;
    assign capture     = ms_to_ws_valid & ws_allowin & accept;

    assign wb_ex         = commit & exc_any;
    assign ertn_flush    = commit & ~exc_any & ws_ertn;
    assign refetch_flush = commit & ~exc_any & ~ws_ertn & ws_refetch;
    assign flush         = wb_ex | ertn_flush | refetch_flush;

    assign wb_ecode    = wb_ex ? sel.ecode    : '0;
    assign wb_esubcode = wb_ex ? sel.esubcode : '0;
    assign wb_badv_we  = wb_ex & sel.badv_en;
    assign wb_badv     = !wb_ex ? '0 : (sel.badv_from_pc ? ws_pc : ws_badv);
    assign wb_pc       = ws_pc;

    assign rf_we    = commit & ws_rf_we & ~exc_any;
    assign rf_waddr = ws_rf_waddr;
    assign rf_wdata = ws_rf_wdata;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_rf_waddr;
    assign debug_wb_rf_wdata = ws_rf_wdata;

    // SQUASH keeps allowin high so MEM drains, but drops what it offers.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        accept  = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (flush && FLUSH_HOLD > 0) begin
                    state_d = ST_SQUASH;
                    hold_d  = HOLD_W'(FLUSH_HOLD);
                end
            end
            ST_SQUASH: begin
                accept = 1'b0;
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid & accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_pc       <= '0;
            ws_rf_we    <= 1'b0;
            ws_rf_waddr <= '0;
            ws_rf_wdata <= '0;
            ws_exc_vec  <= '0;
            ws_ertn     <= 1'b0;
            ws_refetch  <= 1'b0;
            ws_badv     <= '0;
        end else if (capture) begin
            ws_pc       <= ms_pc;
            ws_rf_we    <= ms_rf_we;
            ws_rf_waddr <= ms_rf_waddr;
            ws_rf_wdata <= ms_rf_wdata;
            ws_exc_vec  <= ms_exc_vec;
            ws_ertn     <= ms_ertn;
            ws_refetch  <= ms_refetch;
            ws_badv     <= ms_badv;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retire_cnt <= '0;
            exc_cnt    <= '0;
        end else begin
            if (commit & ~exc_any) retire_cnt <= retire_cnt + CNT_W'(1);
            if (wb_ex)             exc_cnt    <= exc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage_exc.sv
// Bench for wb_stage_exc: table of single instructions plus hand sequences for
// squash window, CSR stall, flush/capture collision and mid-operation reset.
module tb_wb_stage_exc;

    localparam int NUM_EXC    = 10;
    localparam int FLUSH_HOLD = 2;
    localparam int CNT_W      = 32;

    logic               clk = 1'b0;
    logic               resetn;
    logic               ms_to_ws_valid;
    logic               ws_allowin;
    logic [31:0]        ms_pc;
    logic               ms_rf_we;
    logic [4:0]         ms_rf_waddr;
    logic [31:0]        ms_rf_wdata;
    logic [NUM_EXC-1:0] ms_exc_vec;
    logic               ms_ertn;
    logic               ms_refetch;
    logic [31:0]        ms_badv;
    logic               csr_stall;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [31:0]        rf_wdata;
    logic               wb_ex;
    logic [5:0]         wb_ecode;
    logic [8:0]         wb_esubcode;
    logic [31:0]        wb_pc;
    logic [31:0]        wb_badv;
    logic               wb_badv_we;
    logic               ertn_flush;
    logic               refetch_flush;
    logic [CNT_W-1:0]   retire_cnt;
    logic [CNT_W-1:0]   exc_cnt;
    logic [31:0]        debug_wb_pc;
    logic [3:0]         debug_wb_rf_we;
    logic [4:0]         debug_wb_rf_wnum;
    logic [31:0]        debug_wb_rf_wdata;

    wb_stage_exc #(.NUM_EXC(NUM_EXC), .FLUSH_HOLD(FLUSH_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_exc_vec(ms_exc_vec), .ms_ertn(ms_ertn), .ms_refetch(ms_refetch), .ms_badv(ms_badv),
        .csr_stall(csr_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_badv(wb_badv), .wb_badv_we(wb_badv_we),
        .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
        .retire_cnt(retire_cnt), .exc_cnt(exc_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [9:0]  exc;
        logic        ertn;
        logic        refetch;
        logic [31:0] badv;
        logic        x_ex;
        logic [5:0]  x_ecode;
        logic [8:0]  x_esub;
        logic        x_bwe;
        logic [31:0] x_badv;
        logic        x_rfwe;
        logic        x_ertnf;
        logic        x_reff;
    } vec_t;

    int     nvec = 0;
    int     nerr = 0;
    int     cyc  = 0;
    int     exp_ret = 0;
    int     exp_exc = 0;
    vec_t   sb[$];
    int     commit_cyc[$];
    vec_t   tbl[14];
    vec_t   e;
    vec_t   tmp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ms_to_ws_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic present(input vec_t v, input bit push);
        ms_to_ws_valid = 1'b1;
        ms_pc       = v.pc;
        ms_rf_we    = v.we;
        ms_rf_waddr = v.waddr;
        ms_rf_wdata = v.wdata;
        ms_exc_vec  = v.exc;
        ms_ertn     = v.ertn;
        ms_refetch  = v.refetch;
        ms_badv     = v.badv;
        if (push) begin
            sb.push_back(v);
            if (v.x_ex) exp_exc++;
            else        exp_ret++;
        end
    endtask

    function automatic vec_t alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        vec_t v;
        v = '{pc, 1'b1, wa, wd, 10'h0, 1'b0, 1'b0, 32'h0,
              1'b0, 6'h0, 9'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every visible commit must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (resetn && (rf_we || wb_ex || ertn_flush || refetch_flush)) begin
            commit_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_commit: got pc %h expected no commit", wb_pc);
            end else begin
                e = sb.pop_front();
                check("wb_pc", wb_pc, e.pc);
                check("wb_ex", 32'(wb_ex), 32'(e.x_ex));
                check("rf_we", 32'(rf_we), 32'(e.x_rfwe));
                check("dbg_rf_we", 32'(debug_wb_rf_we), 32'({4{e.x_rfwe}}));
                check("ertn_flush", 32'(ertn_flush), 32'(e.x_ertnf));
                check("refetch_flush", 32'(refetch_flush), 32'(e.x_reff));
                if (e.x_ex) begin
                    check("ecode", 32'(wb_ecode), 32'(e.x_ecode));
                    check("esubcode", 32'(wb_esubcode), 32'(e.x_esub));
                    check("badv_we", 32'(wb_badv_we), 32'(e.x_bwe));
                    if (e.x_bwe) check("badv", wb_badv, e.x_badv);
                end
                if (e.x_rfwe) begin
                    check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                    check("rf_wdata", rf_wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        //          pc           we waddr wdata         exc      ertn ref  badv          ex ecode  esub bwe badv         rfwe ertnf reff
        tbl[0]  = '{32'h1C000000, 1, 5, 32'hAAAA0005, 10'h000, 0, 0, 32'h0,        0, 6'h00, 0, 0, 32'h0,        1, 0, 0};
        tbl[1]  = '{32'h1C000004, 1, 6, 32'hBBBB0006, 10'h000, 0, 0, 32'h0,        0, 6'h00, 0, 0, 32'h0,        1, 0, 0};
        tbl[2]  = '{32'h1C000008, 1, 7, 32'h00000001, 10'h140, 0, 0, 32'h00001234, 1, 6'h0B, 0, 0, 32'h0,        0, 0, 0};
        tbl[3]  = '{32'h1C00000C, 0, 0, 32'h0,        10'h200, 0, 0, 32'h80000003, 1, 6'h08, 1, 1, 32'h80000003, 0, 0, 0};
        tbl[4]  = '{32'h1C000010, 0, 0, 32'h0,        10'h002, 0, 0, 32'hDEAD0000, 1, 6'h08, 0, 1, 32'h1C000010, 0, 0, 0};
        tbl[5]  = '{32'h1C000014, 1, 3, 32'h00000005, 10'h021, 0, 0, 32'h0,        1, 6'h00, 0, 0, 32'h0,        0, 0, 0};
        tbl[6]  = '{32'h1C000018, 0, 0, 32'h0,        10'h004, 0, 0, 32'h00005555, 1, 6'h3F, 0, 1, 32'h1C000018, 0, 0, 0};
        tbl[7]  = '{32'h1C00001C, 0, 0, 32'h0,        10'h080, 0, 0, 32'h0,        1, 6'h0C, 0, 0, 32'h0,        0, 0, 0};
        tbl[8]  = '{32'h1C000020, 0, 0, 32'h0,        10'h000, 1, 0, 32'h0,        0, 6'h00, 0, 0, 32'h0,        0, 1, 0};
        tbl[9]  = '{32'h1C000024, 1, 9, 32'h00000099, 10'h000, 0, 1, 32'h0,        0, 6'h00, 0, 0, 32'h0,        1, 0, 1};
        tbl[10] = '{32'h1C000028, 0, 0, 32'h0,        10'h020, 1, 0, 32'h0,        1, 6'h0D, 0, 0, 32'h0,        0, 0, 0};
        tbl[11] = '{32'h1C00002C, 0, 0, 32'h0,        10'h010, 0, 0, 32'h0,        1, 6'h07, 0, 1, 32'h1C00002C, 0, 0, 0};
        tbl[12] = '{32'h1C000030, 0, 0, 32'h0,        10'h008, 0, 0, 32'h0,        1, 6'h03, 0, 1, 32'h1C000030, 0, 0, 0};
        tbl[13] = '{32'h1C000034, 0, 0, 32'h0,        10'h300, 0, 0, 32'h00007777, 1, 6'h09, 0, 1, 32'h00007777, 0, 0, 0};

        resetn = 1'b0; csr_stall = 1'b0; ms_to_ws_valid = 1'b0;
        ms_pc = '0; ms_rf_we = 0; ms_rf_waddr = '0; ms_rf_wdata = '0;
        ms_exc_vec = '0; ms_ertn = 0; ms_refetch = 0; ms_badv = '0;
        step(); step();
        @(negedge clk);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_wb_ex", 32'(wb_ex), 0);
        check("rst_flushes", 32'({ertn_flush, refetch_flush, wb_badv_we}), 0);
        check("rst_dbg_we", 32'(debug_wb_rf_we), 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_exc", exc_cnt, 0);
        check("rst_allowin", 32'(ws_allowin), 1);
        resetn = 1'b1;
        step();

        // Table: back-to-back unless the row flushes (then wait out the squash window).
        for (int i = 0; i < 14; i++) begin
            present(tbl[i], 1'b1);
            step();
            if (tbl[i].x_ex || tbl[i].x_ertnf || tbl[i].x_reff) idle(FLUSH_HOLD + 2);
            if (i == 1) begin
                idle(2);
                check("b2b_retire", retire_cnt, 2);
                check("b2b_consecutive", 32'(commit_cyc[1] - commit_cyc[0]), 1);
            end
        end
        idle(2);
        check("tbl_retire", retire_cnt, 32'(exp_ret));
        check("tbl_exc", exc_cnt, 32'(exp_exc));
        check("tbl_drained", 32'(sb.size()), 0);

        // Squash window: two offers after the ertn flush are dropped, the third commits.
        tmp = tbl[8]; tmp.pc = 32'h1C000100;
        present(tmp, 1'b1); step();
        idle(1);
        present(alu(32'h1C000104, 5'd10, 32'h10), 1'b0);
        @(negedge clk); check("squash_allowin0", 32'(ws_allowin), 1);
        step();
        present(alu(32'h1C000108, 5'd11, 32'h11), 1'b0);
        @(negedge clk); check("squash_allowin1", 32'(ws_allowin), 1);
        step();
        present(alu(32'h1C00010C, 5'd12, 32'h12), 1'b1);
        step();
        idle(2);
        check("squash_drained", 32'(sb.size()), 0);

        // Refetch commit while MEM offers a new instruction: the offer is lost.
        tmp = tbl[9]; tmp.pc = 32'h1C000200;
        present(tmp, 1'b1); step();
        present(alu(32'h1C000204, 5'd13, 32'h13), 1'b0); step();
        idle(FLUSH_HOLD + 3);
        check("collide_drained", 32'(sb.size()), 0);

        // CSR stall: S holds for 3 cycles while T waits in MEM.
        present(alu(32'h1C000300, 5'd14, 32'h14), 1'b1); step();
        csr_stall = 1'b1;
        present(alu(32'h1C000304, 5'd15, 32'h15), 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_allowin", 32'(ws_allowin), 0);
            check("stall_rf_we", 32'(rf_we), 0);
            step();
        end
        csr_stall = 1'b0;
        @(negedge clk); check("release_rf_we", 32'(rf_we), 1);
        step();
        idle(2);
        check("stall_drained", 32'(sb.size()), 0);
        check("pre_rst_retire", retire_cnt, 32'(exp_ret));

        // Reset during a stall drops the held instruction.
        present(alu(32'h1C000400, 5'd16, 32'h16), 1'b0); step();
        ms_to_ws_valid = 1'b0;
        csr_stall = 1'b1; step();
        resetn = 1'b0; step();
        @(negedge clk);
        check("midrst_rf_we", 32'(rf_we), 0);
        check("midrst_flags", 32'({wb_ex, ertn_flush, refetch_flush, debug_wb_rf_we}), 0);
        check("midrst_retire", retire_cnt, 0);
        check("midrst_exc", exc_cnt, 0);
        resetn = 1'b1; csr_stall = 1'b0;
        step(); idle(2);
        present(alu(32'h1C000500, 5'd17, 32'h17), 1'b1); step();
        idle(2);
        check("post_rst_retire", retire_cnt, 1);
        check("final_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
